add_share_arb: RTL and testbench
================================

# add_share_arb

Two-requester arbiter and sequencer for the shared 32-bit adder in the CPU datapath. It lets the PC-increment path (requester 0) and the branch-target path (requester 1) time-share one adder instead of each holding its own. It accepts operand pairs over valid/ready, grants round-robin, registers the sum with the winner's ID, and presents it on a valid/ready result port. It sits between the fetch/branch units and the adder.

## Interface
- WIDTH, 32, operand and sum width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b  same as above, for requester 1.
- res_valid  out  1  result register holds a sum.
- res_ready  in  1  consumer takes the result this cycle.
- res_sum  out  WIDTH  registered sum, (a+b) mod 2^WIDTH; the carry is discarded.
- res_id  out  1  requester that produced res_sum.

## Operation
- States:
  - IDLE: result register empty.
  - HOLD: res_valid=1.
- Free condition: free = (state==IDLE) || res_ready.
- Grant rule: grant goes to the single valid requester. When both are valid, it goes to the requester not granted last (round-robin pointer `last`).
- reqK_ready = free && grant==K && !rst. This is combinational from the valids, res_ready and state.
- Accept (any reqK_valid && reqK_ready) at clock edge:
  - res_sum <= reqK_a + reqK_b.
  - res_id <= K.
  - last <= K.
  - state <= HOLD.
- In HOLD with res_ready=1 and no accept: state <= IDLE, res_valid <= 0.
- In HOLD with res_ready=0: the result register, res_id and last are frozen; both readies are 0.
- Requester rules:
  - Once reqK_valid is high, it must stay high with stable operands until reqK_ready.
  - reqK_valid must not depend on reqK_ready.
- Work-conserving: a lone requester is granted every free cycle, regardless of `last`.
- At most one accept per cycle; the non-granted requester waits.

## Timing
- Reset values (rst high at an edge), applied whatever the state, including mid-HOLD:
  - state=IDLE, res_valid=0, res_sum=0, res_id=0.
  - last=1, so requester 0 wins the first contention.
  - Both readies are 0 while rst is high.
  - A held result is discarded, not delivered.
- Latency: accept at edge N makes res_valid=1 with the sum from edge N (visible in cycle N+1).
- Throughput: one result per cycle when res_ready is held high. Drain and refill happen in the same cycle (HOLD to HOLD).
- Simultaneous res_ready=1 and a new accept in HOLD: the new sum replaces the old one at that edge, and the old one counts as consumed.
- Wrap-around: the sum is truncated to WIDTH bits; no overflow flag.
- No combinational path from reqK_a/b to any output; sums are registered.

## Structure
- The shared defines header holds:
  - the WIDTH default (32);
  - state encodings ST_IDLE=1'b0 and ST_HOLD=1'b1;
  - requester IDs RID_PC=0 and RID_BR=1.
- Sub-module rr_pick2: a combinational two-way round-robin picker.
  - Inputs: v0, v1, last.
  - Outputs: gnt_valid, gnt_id.
- Top level contains:
  - the state register, pointer register and result register;
  - the adder expression, fed from a 2:1 operand mux on gnt_id.

## Test plan
- Single request:
  - Stimulus: req0_valid with a=5, b=7, res_ready=1.
  - Response: req0_ready=1 in the same cycle; next cycle res_valid=1, res_sum=12, res_id=0; following cycle res_valid=0.
- Contention:
  - Stimulus: both valid continuously after reset (req0 a=1 b=1; req1 a=0x100 b=4), res_ready=1.
  - Response: res_id sequence 0,1,0,1; res_sum sequence 2,0x104,2,0x104; one result per cycle.
- Wrap-around:
  - Stimulus: req1 a=0xFFFFFFFF, b=2.
  - Response: res_sum=0x00000001, res_id=1.
- Backpressure:
  - Stimulus: a result is held, res_ready=0 for 3 cycles, both requesters valid.
  - Response: res_sum and res_id stable; req0_ready=req1_ready=0. On the cycle res_ready returns to 1, exactly one requester is accepted (the round-robin winner) and the new sum appears next cycle.
- Reset mid-HOLD:
  - Stimulus: rst pulsed for 1 cycle while res_valid=1 and res_ready=0.
  - Response: after the edge, res_valid=0, res_sum=0, res_id=0. The next both-valid cycle grants requester 0.
- Lone requester after its own grant:
  - Stimulus: req1 valid for 3 back-to-back pairs, req0 idle, res_ready=1.
  - Response: req1_ready=1 every cycle; res_id=1 three times.

Source files
------------

// File: rtl/add_share_arb_pkg.sv
// Shared definitions for the adder-sharing arbiter: default width, state
// encodings and requester IDs.
package add_share_arb_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic RID_PC = 1'b0;
  localparam logic RID_BR = 1'b1;

endpackage : add_share_arb_pkg

// File: rtl/add_share_arb_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// contention goes to the requester not granted last.
module rr_pick2
  import add_share_arb_pkg::*;
(
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_valid = v0 | v1;
    gnt_id    = RID_PC;
    if (v0 && v1) begin
      gnt_id = (last == RID_PC) ? RID_BR : RID_PC;
    end else if (v1) begin
      gnt_id = RID_BR;
    end
  end

endmodule : rr_pick2

// File: rtl/add_share_arb.sv
// Arbiter/sequencer sharing one adder between the PC-increment and branch-target
// paths; the winner's sum is registered with its ID on a valid/ready result port.
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_id
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             id_q, id_d;

  logic             gnt_valid, gnt_id;
  logic             free, accept;
  logic [WIDTH-1:0] op_a, op_b;

  rr_pick2 u_pick (
    .v0        (req0_valid),
    .v1        (req1_valid),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // The result slot frees up when empty or when its content leaves this cycle.
  assign free   = (state_q == ST_IDLE) || res_ready;
  assign accept = free && gnt_valid && !rst;

  assign req0_ready = accept && (gnt_id == RID_PC);
  assign req1_ready = accept && (gnt_id == RID_BR);

  assign op_a = (gnt_id == RID_BR) ? req1_a : req0_a;
  assign op_b = (gnt_id == RID_BR) ? req1_b : req0_b;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sum_d   = sum_q;
    id_d    = id_q;
    if (accept) begin
      sum_d   = op_a + op_b;  // carry out is dropped by the WIDTH-bit target
      id_d    = gnt_id;
      last_d  = gnt_id;
      state_d = ST_HOLD;
    end else if (free) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= RID_BR;
      sum_q   <= '0;
      id_q    <= RID_PC;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == ST_HOLD);
  assign res_sum   = sum_q;
  assign res_id    = id_q;

endmodule : add_share_arb

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_add_share_arb;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         v0, v1, rr;
  logic [W-1:0] a0, b0, a1, b1;
  logic         rdy0, rdy1, res_valid, res_id;
  logic [W-1:0] res_sum;

  int total = 0;
  int bad   = 0;

  // Reference model: what the result slot holds and who won contention last.
  logic         m_valid;
  logic [W-1:0] m_sum;
  logic         m_id;
  logic         m_last;
  logic         m_acc0, m_acc1;

  add_share_arb #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v0),
    .req0_ready (rdy0),
    .req0_a     (a0),
    .req0_b     (b0),
    .req1_valid (v1),
    .req1_ready (rdy1),
    .req1_a     (a1),
    .req1_b     (b1),
    .res_valid  (res_valid),
    .res_ready  (rr),
    .res_sum    (res_sum),
    .res_id     (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check readies, clock, check result port.
  task automatic step(input string tag);
    logic slot_free;
    int   winner;  // -1 none, else requester index
    logic [W-1:0] s;
    #1;
    slot_free = !m_valid || rr;
    if (v0 && v1)  winner = (m_last == 1'b1) ? 0 : 1;
    else if (v0)   winner = 0;
    else if (v1)   winner = 1;
    else           winner = -1;
    if (rst || !slot_free) winner = -1;
    m_acc0 = (winner == 0);
    m_acc1 = (winner == 1);
    check({tag, ".rdy0"}, {31'b0, rdy0}, {31'b0, m_acc0});
    check({tag, ".rdy1"}, {31'b0, rdy1}, {31'b0, m_acc1});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_sum   = '0;
      m_id    = 1'b0;
      m_last  = 1'b1;
    end else if (winner >= 0) begin
      s       = (winner == 1) ? a1 + b1 : a0 + b0;
      m_sum   = s;
      m_id    = (winner == 1);
      m_last  = (winner == 1);
      m_valid = 1'b1;
    end else if (slot_free) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, ".vld"}, {31'b0, res_valid}, {31'b0, m_valid});
    if (m_valid || rst) begin
      check({tag, ".sum"}, res_sum, m_sum);
      check({tag, ".id"}, {31'b0, res_id}, {31'b0, m_id});
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic iv0, input logic [W-1:0] ia0, input logic [W-1:0] ib0,
                       input logic iv1, input logic [W-1:0] ia1, input logic [W-1:0] ib1, input logic irr);
    rst = r; v0 = iv0; a0 = ia0; b0 = ib0; v1 = iv1; a1 = ia1; b1 = ib1; rr = irr;
  endtask

  initial begin
    m_valid = 1'b0; m_sum = '0; m_id = 1'b0; m_last = 1'b1; m_acc0 = 1'b0; m_acc1 = 1'b0;
    drive(1'b1, 1'b1, 32'd3, 32'd4, 1'b1, 32'd5, 32'd6, 1'b1);
    @(negedge clk);

    // Reset: readies held low, result port cleared.
    step("rst0");
    step("rst1");
    check("rst.vld", {31'b0, res_valid}, 32'd0);
    check("rst.sum", res_sum, 32'd0);

    // Single request.
    drive(1'b0, 1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 1'b1);
    step("single");
    check("single.sum12", res_sum, 32'd12);
    check("single.id0", {31'b0, res_id}, 32'd0);
    v0 = 1'b0;
    step("single_drain");
    check("single.empty", {31'b0, res_valid}, 32'd0);

    // Contention straight after reset: 0,1,0,1 one per cycle.
    drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    step("cont_rst");
    drive(1'b0, 1'b1, 32'd1, 32'd1, 1'b1, 32'h100, 32'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("cont%0d", i));
      check($sformatf("cont%0d.id", i), {31'b0, res_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("cont%0d.sum", i), res_sum, (i % 2 == 0) ? 32'd2 : 32'h104);
    end

    // Wrap-around on requester 1.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
    step("wrap");
    check("wrap.sum", res_sum, 32'h0000_0001);
    check("wrap.id", {31'b0, res_id}, 32'd1);

    // Backpressure: hold a result for 3 cycles with both requesters waiting.
    drive(1'b0, 1'b1, 32'd10, 32'd20, 1'b1, 32'd30, 32'd40, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp%0d", i));
      check($sformatf("bp%0d.sum", i), res_sum, 32'd1);
    end
    rr = 1'b1;
    step("bp_release");
    check("bp_release.sum", res_sum, 32'd30);  // last was 1, so requester 0 wins

    // Reset mid-HOLD discards the held result; requester 0 wins next contention.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd8, 32'd9, 1'b0);
    step("hold_fill");
    v1 = 1'b0; rst = 1'b1;
    step("hold_rst");
    check("hold_rst.vld", {31'b0, res_valid}, 32'd0);
    check("hold_rst.sum", res_sum, 32'd0);
    drive(1'b0, 1'b1, 32'd2, 32'd2, 1'b1, 32'd7, 32'd7, 1'b1);
    step("post_rst");
    check("post_rst.id", {31'b0, res_id}, 32'd0);

    // Lone requester 1 back to back after its own grant.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd1, 32'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a1 = 32'(i * 16);
      step($sformatf("lone%0d", i));
      check($sformatf("lone%0d.rdy", i), {31'b0, m_acc1}, 32'd1);
      check($sformatf("lone%0d.id", i), {31'b0, res_id}, 32'd1);
    end

    // Random traffic obeying the requester hold-until-ready rules.
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    for (int n = 0; n < 400; n++) begin
      if (!v0 && ($urandom_range(3) != 0)) begin
        v0 = 1'b1;
        a0 = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom;
        b0 = $urandom;
      end
      if (!v1 && ($urandom_range(3) != 0)) begin
        v1 = 1'b1;
        a1 = $urandom;
        b1 = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      rr  = ($urandom_range(3) != 0);
      rst = ($urandom_range(49) == 0);
      step($sformatf("rnd%0d", n));
      if (m_acc0) v0 = 1'b0;
      if (m_acc1) v1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_add_share_arb
